// File: rtl/mix_columns_unit.sv
// AES MixColumns / InvMixColumns over a full 128-bit state, one state per cycle.
// The transform is purely combinational; the result and its valid flag are registered.
module mix_columns_unit (
  input  logic         clock,
  input  logic         reset,
  input  logic         validIn,
  input  logic         inverse,
  input  logic [127:0] in,
  output logic         validOut,
  output logic [127:0] out
);

  // Handshake: validIn qualifies in/inverse at a rising edge; validOut is high for
  // exactly the cycle after acceptance. There is no ready; a state is accepted every cycle.

  logic [127:0] out_q, out_d;
  logic         valid_q, valid_d;
  logic [127:0] mixed;

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] a);
    mul3 = xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] a);
    mul9 = xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] a);
    mulb = xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] a);
    muld = xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] a);
    mule = xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Column bytes a0..a3 sit MSB-first, row 0 in bits [31:24].
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    if (inv) begin
      b0 = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
      b1 = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
      b2 = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
      b3 = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end else begin
      b0 = xt(a0) ^ mul3(a1) ^ a2 ^ a3;
      b1 = a0 ^ xt(a1) ^ mul3(a2) ^ a3;
      b2 = a0 ^ a1 ^ xt(a2) ^ mul3(a3);
      b3 = mul3(a0) ^ a1 ^ a2 ^ xt(a3);
    end
    mix_col = {b0, b1, b2, b3};
  endfunction

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      mixed[127-32*c -: 32] = mix_col(in[127-32*c -: 32], inverse);
    end
  end

  always_comb begin
    valid_d = validIn;
    out_d   = validIn ? mixed : out_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out      = out_q;
  assign validOut = valid_q;

endmodule

// File: tb/tb_mix_columns_unit.sv
// Bench for mix_columns_unit: known FIPS-197 vectors, hold/reset behaviour and
// randomized round trips checked against a matrix-multiply reference over GF(2^8).
module tb_mix_columns_unit;

  logic         clock;
  logic         reset;
  logic         validIn;
  logic         inverse;
  logic [127:0] in;
  logic         validOut;
  logic [127:0] out;

  int n_checks;
  int n_fail;

  mix_columns_unit dut (
    .clock    (clock),
    .reset    (reset),
    .validIn  (validIn),
    .inverse  (inverse),
    .in       (in),
    .validOut (validOut),
    .out      (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Generic shift-and-add GF(2^8) multiply with the AES polynomial.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Circulant matrix times each column of the 4x4 state.
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0] coef [4];
    logic [7:0] st [4][4];
    logic [7:0] acc;
    logic [127:0] r;
    if (inv) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int k = 0; k < 16; k++) st[k % 4][k / 4] = s[127-8*k -: 8];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - row + 4) % 4], st[j][c]);
        r[127-8*(row+4*c) -: 8] = acc;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic inv, input logic [127:0] d);
    validIn = v;
    inverse = inv;
    in      = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    step();
    step();
    n_checks++;
    if (out !== 128'h0 || validOut !== 1'b0) begin
      $display("FAIL reset_state out=%h validOut=%b exp out=0 validOut=0", out, validOut);
      n_fail++;
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, '0);
    step();
    n_checks++;
    if (validOut !== 1'b0) begin
      $display("FAIL reset_no_emit validOut=%b exp 0", validOut);
      n_fail++;
    end
  endtask

  task automatic test_fips_vectors();
    drive(1'b1, 1'b0, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
    step();
    drive(1'b0, 1'b0, '0);
    n_checks++;
    if (out !== 128'h046681e5e0cb199a48f8d37a2806264c || validOut !== 1'b1) begin
      $display("FAIL fips_fwd out=%h v=%b exp 046681e5e0cb199a48f8d37a2806264c v=1", out, validOut);
      n_fail++;
    end
    step();
    n_checks++;
    if (validOut !== 1'b0) begin
      $display("FAIL fips_single_pulse validOut=%b exp 0", validOut);
      n_fail++;
    end
    drive(1'b1, 1'b1, 128'h046681e5e0cb199a48f8d37a2806264c);
    step();
    n_checks++;
    if (out !== 128'hd4bf5d30e0b452aeb84111f11e2798e5 || validOut !== 1'b1) begin
      $display("FAIL fips_inv out=%h v=%b exp d4bf5d30e0b452aeb84111f11e2798e5 v=1", out, validOut);
      n_fail++;
    end
    drive(1'b0, 1'b0, '0);
    step();
  endtask

  task automatic test_column_vectors();
    logic [31:0] col_in  [6];
    logic [31:0] col_out [6];
    col_in[0] = 32'hdb135345; col_out[0] = 32'h8e4da1bc;
    col_in[1] = 32'hf20a225c; col_out[1] = 32'h9fdc589d;
    col_in[2] = 32'h01010101; col_out[2] = 32'h01010101;
    col_in[3] = 32'hc6c6c6c6; col_out[3] = 32'hc6c6c6c6;
    col_in[4] = 32'hd4d4d4d5; col_out[4] = 32'hd5d5d7d6;
    col_in[5] = 32'h2d26314c; col_out[5] = 32'h4d7ebdf8;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, {4{col_in[i]}});
      step();
      n_checks++;
      if (out !== {4{col_out[i]}} || validOut !== 1'b1) begin
        $display("FAIL column_fwd[%0d] out=%h v=%b exp %h v=1", i, out, validOut, {4{col_out[i]}});
        n_fail++;
      end
      drive(1'b1, 1'b1, {4{col_out[i]}});
      step();
      n_checks++;
      if (out !== {4{col_in[i]}} || validOut !== 1'b1) begin
        $display("FAIL column_inv[%0d] out=%h v=%b exp %h v=1", i, out, validOut, {4{col_in[i]}});
        n_fail++;
      end
    end
    // Distinct columns catch any cross-column mixing.
    drive(1'b1, 1'b0, {col_in[0], col_in[1], col_in[4], col_in[5]});
    step();
    drive(1'b0, 1'b0, '0);
    n_checks++;
    if (out !== {col_out[0], col_out[1], col_out[4], col_out[5]}) begin
      $display("FAIL column_mixed out=%h exp %h", out, {col_out[0], col_out[1], col_out[4], col_out[5]});
      n_fail++;
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b, d, exp;
    logic inv;
    a = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    b = 128'h046681e5e0cb199a48f8d37a2806264c;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, k[0], k[0] ? b : a);
      step();
      exp = k[0] ? a : b;
      n_checks++;
      if (out !== exp || validOut !== 1'b1) begin
        $display("FAIL b2b_fips[%0d] out=%h v=%b exp %h v=1", k, out, validOut, exp);
        n_fail++;
      end
    end
    for (int k = 0; k < 16; k++) begin
      d   = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'($urandom_range(0, 1));
      drive(1'b1, inv, d);
      step();
      exp = model(d, inv);
      n_checks++;
      if (out !== exp || validOut !== 1'b1) begin
        $display("FAIL b2b_rand[%0d] out=%h v=%b exp %h v=1", k, out, validOut, exp);
        n_fail++;
      end
    end
    drive(1'b0, 1'b0, '0);
    step();
  endtask

  task automatic test_hold();
    logic [127:0] d, exp;
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = model(d, 1'b0);
    drive(1'b1, 1'b0, d);
    step();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), {$urandom(), $urandom(), $urandom(), $urandom()});
      step();
      n_checks++;
      if (out !== exp || validOut !== 1'b0) begin
        $display("FAIL hold[%0d] out=%h v=%b exp %h v=0", k, out, validOut, exp);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [127:0] d;
    d = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    drive(1'b1, 1'b0, d);
    step();
    reset = 1'b1;
    drive(1'b1, 1'b1, 128'h046681e5e0cb199a48f8d37a2806264c);
    step();
    n_checks++;
    if (out !== 128'h0 || validOut !== 1'b0) begin
      $display("FAIL reset_priority out=%h v=%b exp 0 v=0", out, validOut);
      n_fail++;
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, d);
    step();
    n_checks++;
    if (out !== 128'h0 || validOut !== 1'b0) begin
      $display("FAIL reset_discard out=%h v=%b exp 0 v=0", out, validOut);
      n_fail++;
    end
  endtask

  task automatic test_midstream_reset();
    logic [127:0] c, exp;
    drive(1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()});
    step();
    reset = 1'b1;
    drive(1'b1, 1'b0, {$urandom(), $urandom(), $urandom(), $urandom()});
    step();
    n_checks++;
    if (out !== 128'h0 || validOut !== 1'b0) begin
      $display("FAIL midstream_reset out=%h v=%b exp 0 v=0", out, validOut);
      n_fail++;
    end
    reset = 1'b0;
    c = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = model(c, 1'b1);
    drive(1'b1, 1'b1, c);
    step();
    drive(1'b0, 1'b0, '0);
    n_checks++;
    if (out !== exp || validOut !== 1'b1) begin
      $display("FAIL post_reset_first out=%h v=%b exp %h v=1", out, validOut, exp);
      n_fail++;
    end
    step();
  endtask

  task automatic test_random_roundtrip();
    logic [127:0] orig, fwd;
    for (int k = 0; k < 1000; k++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom()};
      drive(1'b1, 1'b0, orig);
      step();
      n_checks++;
      if (out !== model(orig, 1'b0) || validOut !== 1'b1) begin
        $display("FAIL rt_fwd[%0d] out=%h v=%b exp %h v=1", k, out, validOut, model(orig, 1'b0));
        n_fail++;
      end
      fwd = model(orig, 1'b0);
      drive(1'b1, 1'b1, fwd);
      step();
      n_checks++;
      if (out !== orig || validOut !== 1'b1) begin
        $display("FAIL rt_inv[%0d] out=%h v=%b exp %h v=1", k, out, validOut, orig);
        n_fail++;
      end
    end
    drive(1'b0, 1'b0, '0);
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, '0);
    test_reset();
    test_fips_vectors();
    test_column_vectors();
    test_back_to_back();
    test_hold();
    test_reset_priority();
    test_midstream_reset();
    test_random_roundtrip();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
